mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single CPU-side data port of the address bridge between two masters: m0 (CPU load/store unit) and m1 (DMA/debug master).
- Each accepted request becomes one sequenced bus transaction: an address phase, an optional read-wait phase, then a response phase with a one-cycle ack.
- Sits between the masters and the bridge's temp_m_data_* inputs. The bridge itself still does all DM/TC1/TC2/interrupt address decoding.

Parameters:
- RD_LAT, 0: cycles from address phase to valid bus_rdata. 0 means combinational read, same cycle. Legal range 0..7.
- FIXED_PRIO, 0: 0 means round-robin between m0 and m1; 1 means m0 always wins a tie.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  m0 request; held with addr/wdata/byteen stable until m0_ack
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_byteen  in  4  m0 byte enables; 4'h0 means read
- m0_ack  out  1  one-cycle completion pulse to m0
- m0_rdata  out  32  registered read data; valid while m0_ack=1, held until m0's next ack
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_ack, m1_rdata: same widths and meanings for m1
- bus_addr  out  32  to bridge temp_m_data_addr
- bus_wdata  out  32  to bridge temp_m_data_wdata
- bus_byteen  out  4  to bridge temp_m_data_byteen
- bus_rdata  in  32  from bridge temp_m_data_rdata
- grant  out  2  one-hot owner of the current transaction; 2'b00 in IDLE
- busy  out  1  1 in any state other than IDLE

Behaviour:
- FSM states: IDLE, ADDR, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - State goes to IDLE immediately.
  - All outputs 0, including bus_byteen, so no write is issued.
  - last_grant=m1, so m0 wins the first tie.
  - Wait counter 0; m0_rdata and m1_rdata 0.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one req: that master wins.
  - Both req, FIXED_PRIO=1: m0 wins.
  - Both req, FIXED_PRIO=0: the master not equal to last_grant wins.
  - On a win: latch the winner's addr/wdata/byteen into internal registers, update last_grant, go to ADDR.
- Bus outputs:
  - Driven from the latched registers, never directly from master inputs.
  - In IDLE and RESP: bus_addr=0, bus_wdata=0, bus_byteen=0.
- ADDR (exactly one cycle):
  - bus_addr and bus_wdata driven; bus_byteen = latched byteen.
  - Write (byteen≠0): byteen is asserted in this cycle only, so exactly one write per transaction; next state RESP.
  - Read, RD_LAT=0: sample bus_rdata at the end of ADDR, go to RESP.
  - Read, RD_LAT>0: load counter with RD_LAT, go to WAIT.
- WAIT:
  - bus_addr held; bus_byteen=0.
  - Counter decrements each cycle.
  - On the cycle the counter equals 1: sample bus_rdata into the owner's rdata register, go to RESP.
  - Counter width is 3 bits with no wrap; WAIT lasts exactly RD_LAT cycles.
- RESP (one cycle):
  - Owner's ack=1; the other master's ack=0.
  - Owner's rdata is valid; for writes it is unchanged.
  - Next state IDLE.
- Latency, request first seen high in IDLE at cycle N:
  - Address phase at N+1.
  - Ack at N+2 for writes, or N+2+RD_LAT for reads.
  - Back-to-back issue rate: one transaction per 3+(read?RD_LAT:0) cycles.
- Request dropped after latch: the transaction still completes, ack still pulses once, and the master ignores it. The dropped request does not reissue.
- req still high in the IDLE after RESP: treated as a new request and re-arbitrated. Under round-robin, a waiting other master wins.
- m_rdata of the non-owning master is never modified.
- grant is one-hot in ADDR, WAIT and RESP, and matches the latched owner.

Test Plan:
1. RD_LAT=0; m0 writes addr 0x0000_0100, wdata 0xDEADBEEF, byteen 4'hF from IDLE at cycle N.
   - Required: bus_byteen=4'hF only at N+1; m0_ack=1 only at N+2; m1_ack stays 0; grant=2'b01 at N+1..N+2.
2. RD_LAT=2; m1 reads addr 0x0000_7F04 with bus_rdata=0x12345678.
   - Required: bus_addr=0x7F04 at N+1..N+3; bus_byteen=0 throughout; m1_ack at N+4 with m1_rdata=0x12345678.
   - m0_rdata unchanged.
3. FIXED_PRIO=0; m0 and m1 both hold req with writes from reset release.
   - Required: acks go m0, m1, m0, m1, spaced 3 cycles apart.
   - Same stimulus with FIXED_PRIO=1: m0 acked every 3 cycles, m1 never acked.
4. RD_LAT=3; assert reset in WAIT.
   - Required: in the same cycle, state is IDLE and every output is 0.
   - After release with no req: no ack, busy=0.
   - First tie after release goes to m0.
5. m0 read with RD_LAT=1; drop m0_req at N+1.
   - Required: m0_ack still pulses exactly once at N+3; grant=0 and busy=0 from N+4.
6. Write byteen=4'b0011 at addr 0x0000_7F10 (TC1 range).
   - Required: bus_byteen=4'b0011 for exactly one cycle.
   - A second write queued behind it does not overlap; its bus_byteen is asserted 3 cycles later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the bridge's CPU-side data port. It runs one bus
// transaction at a time: an address phase, an optional read wait, then a one-cycle ack.
module mem_port_arbiter #(
  parameter int RD_LAT     = 0,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t      state, state_next;
  logic        owner;
  logic        last_grant;
  logic [2:0]  cnt;
  logic [31:0] addr_lat;
  logic [31:0] wdata_lat;
  logic [3:0]  byteen_lat;
  logic        take;
  logic        win_m1;
  logic        sample;
  logic        is_read;

  assign is_read = (byteen_lat == 4'h0);

  // owner/last_grant encode the master as 0 = m0, 1 = m1
  always_comb begin
    state_next = state;
    take       = 1'b0;
    win_m1     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take       = 1'b1;
          state_next = ADDR;
          if (m0_req && m1_req) win_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
          else                  win_m1 = m1_req;
        end
      end
      ADDR: begin
        if (!is_read || LAT == 3'd0) begin
          sample     = is_read;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          sample     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 3'd0;
      m0_rdata   <= 32'h0;
      m1_rdata   <= 32'h0;
    end else begin
      state <= state_next;
      if (take) begin
        owner      <= win_m1;
        last_grant <= win_m1;
      end
      if (state == ADDR && is_read) cnt <= LAT;
      else if (state == WAIT)       cnt <= cnt - 3'd1;
      if (sample) begin
        if (owner) m1_rdata <= bus_rdata;
        else       m0_rdata <= bus_rdata;
      end
    end
  end

  // Request fields are captured once at arbitration; the bus never sees live master inputs
  always_ff @(posedge clk) begin
    if (take) begin
      addr_lat   <= win_m1 ? m1_addr   : m0_addr;
      wdata_lat  <= win_m1 ? m1_wdata  : m0_wdata;
      byteen_lat <= win_m1 ? m1_byteen : m0_byteen;
    end
  end

  always_comb begin
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;
    bus_byteen = 4'h0;
    if (state == ADDR || state == WAIT) begin
      bus_addr  = addr_lat;
      bus_wdata = wdata_lat;
    end
    if (state == ADDR) bus_byteen = byteen_lat;
  end

  assign busy   = (state != IDLE);
  assign grant  = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign m0_ack = (state == RESP) && !owner;
  assign m1_ack = (state == RESP) &&  owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances, where instance g has RD_LAT=g and instance 1 uses fixed priority.
// Checks come from directed vectors, hand sequences, and random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N = 4;

  typedef logic [136:0] ovec_t;

  typedef struct {
    int          inst;
    logic        r0;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        r1;
    logic [31:0] a1, w1;
    logic [3:0]  b1;
    logic [31:0] rd;
    ovec_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req [N];
  logic [31:0] m0_addr [N];
  logic [31:0] m0_wdata [N];
  logic [3:0]  m0_byteen [N];
  logic        m0_ack [N];
  logic [31:0] m0_rdata [N];
  logic        m1_req [N];
  logic [31:0] m1_addr [N];
  logic [31:0] m1_wdata [N];
  logic [3:0]  m1_byteen [N];
  logic        m1_ack [N];
  logic [31:0] m1_rdata [N];
  logic [31:0] bus_addr [N];
  logic [31:0] bus_wdata [N];
  logic [3:0]  bus_byteen [N];
  logic [31:0] bus_rdata [N];
  logic [1:0]  grant [N];
  logic        busy [N];

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.RD_LAT(g), .FIXED_PRIO(g == 1 ? 1 : 0)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_byteen(m0_byteen[g]), .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_byteen(m1_byteen[g]), .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
      .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]), .bus_byteen(bus_byteen[g]),
      .bus_rdata(bus_rdata[g]), .grant(grant[g]), .busy(busy[g])
    );
  end

  function automatic ovec_t mk(input logic [1:0] gr, input logic bs, input logic k0, input logic k1,
                               input logic [3:0] bb, input logic [31:0] ba, input logic [31:0] bw,
                               input logic [31:0] r0, input logic [31:0] r1);
    return {gr, bs, k0, k1, bb, ba, bw, r0, r1};
  endfunction

  function automatic ovec_t outs(input int i);
    return {grant[i], busy[i], m0_ack[i], m1_ack[i], bus_byteen[i], bus_addr[i],
            bus_wdata[i], m0_rdata[i], m1_rdata[i]};
  endfunction

  task automatic check(input string name, input ovec_t act, input ovec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      m0_req[i] = 1'b0; m0_addr[i] = 32'h0; m0_wdata[i] = 32'h0; m0_byteen[i] = 4'h0;
      m1_req[i] = 1'b0; m1_addr[i] = 32'h0; m1_wdata[i] = 32'h0; m1_byteen[i] = 4'h0;
      bus_rdata[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic add(input int inst, input logic r0, input logic [31:0] a0, input logic [31:0] w0,
                     input logic [3:0] b0, input logic r1, input logic [31:0] a1, input logic [31:0] w1,
                     input logic [3:0] b1, input logic [31:0] rd, input ovec_t exp);
    vec_t v;
    v.inst = inst; v.r0 = r0; v.a0 = a0; v.w0 = w0; v.b0 = b0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.b1 = b1; v.rd = rd; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_random(input int g, input int ncyc);
    logic        lastg;
    logic        own;
    bit          act;
    bit          seen0, seen1;
    int          s, k, lat;
    logic [31:0] ta, tw;
    logic [3:0]  tb;
    logic [31:0] mrd [2];
    ovec_t       e, m;
    lastg = 1'b1; own = 1'b0; act = 0; seen0 = 0; seen1 = 0; s = 0;
    ta = 32'h0; tw = 32'h0; tb = 4'h0; mrd[0] = 32'h0; mrd[1] = 32'h0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (seen0 || !m0_req[g]) begin
        m0_req[g]    = ($urandom_range(0, 2) == 0);
        m0_addr[g]   = $urandom;
        m0_wdata[g]  = $urandom;
        m0_byteen[g] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (seen1 || !m1_req[g]) begin
        m1_req[g]    = ($urandom_range(0, 2) == 0);
        m1_addr[g]   = $urandom;
        m1_wdata[g]  = $urandom;
        m1_byteen[g] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      bus_rdata[g] = $urandom;
      @(negedge clk);
      e = mk(2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, mrd[0], mrd[1]);
      m = '1;
      k = 0; lat = 0;
      if (act) begin
        k   = c - s;
        lat = (tb == 4'h0) ? g : 0;
        if (k == 1)
          e = mk(own ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b0, tb, ta, tw, mrd[0], mrd[1]);
        else if (k <= 1 + lat) begin
          e = mk(own ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b0, 4'h0, ta, 32'h0, mrd[0], mrd[1]);
          m = mk(2'b11, 1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        end else
          e = mk(own ? 2'b10 : 2'b01, 1'b1, !own, own, 4'h0, 32'h0, 32'h0, mrd[0], mrd[1]);
      end
      check($sformatf("rand_i%0d_c%0d", g, c), outs(g) & m, e & m);
      if (act) begin
        if (tb == 4'h0 && k == 1 + lat) mrd[own] = bus_rdata[g];
        if (k == 2 + lat) act = 0;
      end else if (m0_req[g] || m1_req[g]) begin
        if (m0_req[g] && m1_req[g]) own = (g == 1) ? 1'b0 : !lastg;
        else                        own = m1_req[g];
        lastg = own;
        act   = 1;
        s     = c;
        ta    = own ? m1_addr[g]   : m0_addr[g];
        tw    = own ? m1_wdata[g]  : m0_wdata[g];
        tb    = own ? m1_byteen[g] : m0_byteen[g];
      end
      seen0 = m0_ack[g];
      seen1 = m1_ack[g];
    end
  endtask

  initial begin
    vec_t v;
    int   nack;
    ovec_t z;
    z = '0;

    // m0 single write on RD_LAT=0
    add(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, mk(2'b01, 1, 0, 0, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0));
    add(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, mk(2'b01, 1, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // m1 read on RD_LAT=2
    add(2, 0, 0, 0, 0, 1, 32'h7F04, 0, 0, 32'h12345678, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(2, 0, 0, 0, 0, 1, 32'h7F04, 0, 0, 32'h12345678, mk(2'b10, 1, 0, 0, 0, 32'h7F04, 0, 0, 0));
    add(2, 0, 0, 0, 0, 1, 32'h7F04, 0, 0, 32'h12345678, mk(2'b10, 1, 0, 0, 0, 32'h7F04, 0, 0, 0));
    add(2, 0, 0, 0, 0, 1, 32'h7F04, 0, 0, 32'h12345678, mk(2'b10, 1, 0, 0, 0, 32'h7F04, 0, 0, 0));
    add(2, 0, 0, 0, 0, 1, 32'h7F04, 0, 0, 32'h12345678, mk(2'b10, 1, 0, 1, 0, 0, 0, 0, 32'h12345678));
    add(2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678));
    // partial write then a queued write; m0 won last, so the tie goes to m1
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 1, 32'h7F10, 32'hA5A5A5A5, 4'h3, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 1, 32'h7F10, 32'hA5A5A5A5, 4'h3, 0, mk(2'b10, 1, 0, 0, 4'h3, 32'h7F10, 32'hA5A5A5A5, 0, 0));
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 1, 32'h7F10, 32'hA5A5A5A5, 4'h3, 0, mk(2'b10, 1, 0, 1, 0, 0, 0, 0, 0));
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 0, 0, 0, 0, 0, mk(2'b01, 1, 0, 0, 4'hC, 32'h200, 32'h11223344, 0, 0));
    add(0, 1, 32'h200, 32'h11223344, 4'hC, 0, 0, 0, 0, 0, mk(2'b01, 1, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    clear_inputs();
    #2;
    for (int i = 0; i < N; i++) check($sformatf("in_reset_i%0d", i), outs(i), z);
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("after_reset_i%0d", i), outs(i), z);

    foreach (tbl[i]) begin
      v = tbl[i];
      @(posedge clk);
      #1;
      m0_req[v.inst] = v.r0; m0_addr[v.inst] = v.a0; m0_wdata[v.inst] = v.w0; m0_byteen[v.inst] = v.b0;
      m1_req[v.inst] = v.r1; m1_addr[v.inst] = v.a1; m1_wdata[v.inst] = v.w1; m1_byteen[v.inst] = v.b1;
      bus_rdata[v.inst] = v.rd;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(v.inst), v.exp);
    end

    // both masters hold write requests from reset release
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m0_req[i] = 1'b1; m0_addr[i] = 32'h10; m0_wdata[i] = 32'hAAAA0000; m0_byteen[i] = 4'hF;
      m1_req[i] = 1'b1; m1_addr[i] = 32'h20; m1_wdata[i] = 32'hBBBB0000; m1_byteen[i] = 4'hF;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check($sformatf("rr_acks_c%0d", c), ovec_t'({m0_ack[0], m1_ack[0]}),
            ovec_t'({c % 6 == 2, c % 6 == 5}));
      check($sformatf("fp_acks_c%0d", c), ovec_t'({m0_ack[1], m1_ack[1]}),
            ovec_t'({c % 3 == 2, 1'b0}));
    end

    // reset asserted mid-WAIT on RD_LAT=3
    do_reset();
    @(posedge clk);
    #1;
    m0_req[3] = 1'b1; m0_addr[3] = 32'h300; m0_byteen[3] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wait_before_reset", ovec_t'({busy[3], grant[3], bus_addr[3]}), ovec_t'({1'b1, 2'b01, 32'h300}));
    #2 reset = 1'b0;
    m0_req[3] = 1'b0;
    #1 check("async_reset_outs", outs(3), z);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("idle_after_reset_c%0d", c), outs(3), z);
    end
    @(posedge clk);
    #1;
    m0_req[3] = 1'b1; m0_byteen[3] = 4'h1; m0_addr[3] = 32'h40;
    m1_req[3] = 1'b1; m1_byteen[3] = 4'h2; m1_addr[3] = 32'h50;
    @(negedge clk);
    @(negedge clk);
    check("first_tie_m0", ovec_t'({grant[3], bus_byteen[3]}), ovec_t'({2'b01, 4'h1}));

    // m0 read on RD_LAT=1 with the request dropped after latch
    do_reset();
    @(posedge clk);
    #1;
    m0_req[1] = 1'b1; m0_addr[1] = 32'h400; m0_byteen[1] = 4'h0; bus_rdata[1] = 32'hCAFEF00D;
    nack = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (m0_ack[1]) nack++;
      check($sformatf("drop_ack_c%0d", c), ovec_t'({m0_ack[1], m1_ack[1]}), ovec_t'({c == 3, 1'b0}));
      if (c == 3) check("drop_rdata", ovec_t'({m0_rdata[1], m1_rdata[1]}), ovec_t'({32'hCAFEF00D, 32'h0}));
      if (c >= 4) check($sformatf("drop_idle_c%0d", c), ovec_t'({grant[1], busy[1]}), ovec_t'(3'b000));
      if (c == 0) begin
        @(posedge clk);
        #1 m0_req[1] = 1'b0;
      end
    end
    check("drop_ack_count", ovec_t'(nack), ovec_t'(1));

    for (int g = 0; g < N; g++) run_random(g, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
